// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator.
// Compares two WIDTH-bit operands CHUNK bits per clock, starting with the
// most significant chunk, and stops at the first chunk that differs.
// Signed compares flip the sign bit of both operands at capture. This
// offset-binary mapping lets one unsigned chunk compare serve both modes.
//
// Handshake: a compare is accepted on a rising edge where start=1 and
// busy=0. busy stays high while chunks are being compared. done pulses for
// one cycle, and in that cycle busy=0, so a new start is accepted with no
// gap. g/eq/l are registered and hold their value until the next done.
// start is ignored while busy=1.
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             eq,
    output logic             l
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CMP  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] flip;
    logic [IDX_W-1:0] idx;
    logic [CHUNK-1:0] top_a;
    logic [CHUNK-1:0] top_b;

    // Sign-bit mask applied at capture when a signed compare is requested
    always_comb begin
        flip = '0;
        flip[WIDTH-1] = signed_mode;
    end

    assign top_a = sh_a[WIDTH-1 -: CHUNK];
    assign top_b = sh_b[WIDTH-1 -: CHUNK];

    // busy is a direct decode of the state register, so it has no input path
    assign busy = (state == CMP);

    // Capture operands, walk chunks MSB first, and register held results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            idx   <= '0;
            done  <= 1'b0;
            g     <= 1'b0;
            eq    <= 1'b0;
            l     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a ^ flip;
                        sh_b  <= b ^ flip;
                        idx   <= '0;
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (top_a != top_b) begin
                        g     <= (top_a > top_b);
                        l     <= (top_a < top_b);
                        eq    <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (idx == LAST_IDX) begin
                        g     <= 1'b0;
                        l     <= 1'b0;
                        eq    <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        sh_a <= sh_a << CHUNK;
                        sh_b <= sh_b << CHUNK;
                        idx  <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator.
// The directed steps cover reset, latency, signed mode, the handshake, and
// reset in the middle of a compare. Random steps then check a 16/4 instance
// and three parameter-sweep instances against an arithmetic reference model.
module tb_seq_magnitude_comparator;

    localparam logic [2:0] R_G = 3'b100;
    localparam logic [2:0] R_E = 3'b010;
    localparam logic [2:0] R_L = 3'b001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // main instance, WIDTH=16 CHUNK=4
    logic        start0 = 1'b0;
    logic        sm0 = 1'b0;
    logic [15:0] a0 = '0;
    logic [15:0] b0 = '0;
    logic        busy0, done0, g0, eq0, l0;

    // sweep instances share start/signed_mode
    logic        start_s = 1'b0;
    logic        sm_s = 1'b0;
    logic [15:0] a1 = '0, b1 = '0;
    logic [7:0]  a2 = '0, b2 = '0;
    logic [31:0] a3 = '0, b3 = '0;
    logic        busy1, done1, g1, eq1, l1;
    logic        busy2, done2, g2, eq2, l2;
    logic        busy3, done3, g3, eq3, l3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(sm0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .g(g0), .eq(eq0), .l(l0));

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .signed_mode(sm_s),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .g(g1), .eq(eq1), .l(l1));

    seq_magnitude_comparator #(.WIDTH(8), .CHUNK(8)) u_c8w8 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .signed_mode(sm_s),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .g(g2), .eq(eq2), .l(l2));

    seq_magnitude_comparator #(.WIDTH(32), .CHUNK(8)) u_c8w32 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .signed_mode(sm_s),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .g(g3), .eq(eq3), .l(l3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: numeric compare of the operand values, and latency taken
    // from the position of the first chunk where the raw operands differ.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input int w, input int ch, input logic sm,
                                      output logic [2:0] res, output int lat);
        longint ua, ub, va, vb, cm;
        bit found;
        ua = longint'({32'b0, a}) & ((64'sd1 <<< w) - 1);
        ub = longint'({32'b0, b}) & ((64'sd1 <<< w) - 1);
        va = (sm && a[w-1]) ? ua - (64'sd1 <<< w) : ua;
        vb = (sm && b[w-1]) ? ub - (64'sd1 <<< w) : ub;
        res = (va > vb) ? R_G : ((va < vb) ? R_L : R_E);
        cm = (64'sd1 <<< ch) - 1;
        lat = w / ch;
        found = 1'b0;
        for (int k = 0; k < w / ch; k++) begin
            if (!found && (((ua >>> (w - ch * (k + 1))) & cm) != ((ub >>> (w - ch * (k + 1))) & cm))) begin
                lat = k + 1;
                found = 1'b1;
            end
        end
    endfunction

    // Called just after the accepting edge; counts edges until done
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (done0 !== 1'b1 && lat < 40) begin
            if (busy0 === 1'b1) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic run_main(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic sm, input int exp_lat, input logic [2:0] exp_res);
        int lat, bcnt;
        a0 = a; b0 = b; sm0 = sm; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done(lat, bcnt);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bcnt), 32'(exp_lat));
        check({tag, "_res"}, 32'({g0, eq0, l0}), 32'(exp_res));
        check({tag, "_busy_at_done"}, 32'(busy0), 32'd0);
    endtask

    function automatic logic [31:0] gen_b(input logic [31:0] a, input int w);
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return a;
        if (sel == 1) return a ^ (32'd1 << $urandom_range(0, w - 1));
        return $urandom;
    endfunction

    initial begin
        logic [2:0] er;
        int el, lat, bcnt, cyc;
        int lat1, lat2, lat3;
        logic [2:0] r1, r2, r3;
        logic [31:0] ra, rb;
        int pulses;

        // reset held
        tick(); tick();
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_res", 32'({g0, eq0, l0}), 32'd0);
        rst_n = 1'b1;
        tick();

        // directed compares
        run_main("u_low", 16'h1234, 16'h1235, 1'b0, 4, R_L);
        run_main("u_eq", 16'hABCD, 16'hABCD, 1'b0, 4, R_E);
        run_main("u_early", 16'h8000, 16'h7FFF, 1'b0, 1, R_G);
        run_main("s_early", 16'h8000, 16'h7FFF, 1'b1, 1, R_L);
        run_main("s_neg", 16'hFFFF, 16'hFFFE, 1'b1, 4, R_G);

        // asynchronous reset mid-cycle, no clock edge needed
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_done", 32'(done0), 32'd0);
        check("arst_res", 32'({g0, eq0, l0}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // start held high during busy with new operands: ignored
        a0 = 16'h1234; b0 = 16'h1235; sm0 = 1'b0; start0 = 1'b1;
        tick();
        a0 = 16'h0000; b0 = 16'hFFFF; sm0 = 1'b1;
        wait_done(lat, bcnt);
        check("hold_lat", 32'(lat), 32'd4);
        check("hold_res", 32'({g0, eq0, l0}), 32'(R_L));
        // start in the done cycle: accepted with no gap
        a0 = 16'h0001; b0 = 16'h0000; sm0 = 1'b0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("b2b_busy", 32'(busy0), 32'd1);
        wait_done(lat, bcnt);
        check("b2b_lat", 32'(lat), 32'd4);
        check("b2b_res", 32'({g0, eq0, l0}), 32'(R_G));

        // results hold while inputs wander without start
        for (int i = 0; i < 5; i++) begin
            a0 = 16'($urandom); b0 = 16'($urandom); sm0 = 1'($urandom);
            tick();
        end
        check("hold_done", 32'(done0), 32'd0);
        check("hold_keep", 32'({g0, eq0, l0}), 32'(R_G));

        // reset during CMP aborts with no done pulse
        a0 = 16'h5555; b0 = 16'h5555; sm0 = 1'b0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy0), 32'd0);
        check("mid_res", 32'({g0, eq0, l0}), 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) rst_n = 1'b1;
            tick();
            if (done0 === 1'b1) pulses++;
        end
        check("mid_nodone", 32'(pulses), 32'd0);
        check("mid_res_after", 32'({g0, eq0, l0}), 32'd0);
        run_main("after_rst", 16'h0010, 16'h0100, 1'b0, 2, R_L);

        // random compares on the main instance
        for (int i = 0; i < 20; i++) begin
            ra = {16'b0, 16'($urandom)};
            rb = {16'b0, gen_b(ra, 16)};
            rb[31:16] = '0;
            sm0 = 1'($urandom);
            ref_model(ra, rb, 16, 4, sm0, er, el);
            run_main("rnd16", ra[15:0], rb[15:0], sm0, el, er);
        end

        // parameter sweep: three instances started together
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = gen_b(ra, 32);
            a3 = ra; b3 = rb;
            a1 = ra[15:0]; b1 = gen_b({16'b0, ra[15:0]}, 16) & 32'h0000FFFF;
            a2 = ra[7:0];  b2 = 8'(gen_b({24'b0, ra[7:0]}, 8));
            sm_s = 1'($urandom);
            start_s = 1'b1;
            tick();
            start_s = 1'b0;
            lat1 = 0; lat2 = 0; lat3 = 0;
            r1 = '0; r2 = '0; r3 = '0;
            cyc = 0;
            while ((lat1 == 0 || lat2 == 0 || lat3 == 0) && cyc < 40) begin
                tick();
                cyc++;
                if (done1 === 1'b1 && lat1 == 0) begin lat1 = cyc; r1 = {g1, eq1, l1}; end
                if (done2 === 1'b1 && lat2 == 0) begin lat2 = cyc; r2 = {g2, eq2, l2}; end
                if (done3 === 1'b1 && lat3 == 0) begin lat3 = cyc; r3 = {g3, eq3, l3}; end
            end
            ref_model({16'b0, a1}, {16'b0, b1}, 16, 1, sm_s, er, el);
            check("sw_c1_lat", 32'(lat1), 32'(el));
            check("sw_c1_res", 32'(r1), 32'(er));
            check("sw_c1_onehot", 32'($countones(r1)), 32'd1);
            ref_model({24'b0, a2}, {24'b0, b2}, 8, 8, sm_s, er, el);
            check("sw_c8w8_lat", 32'(lat2), 32'(el));
            check("sw_c8w8_res", 32'(r2), 32'(er));
            check("sw_c8w8_onehot", 32'($countones(r2)), 32'd1);
            ref_model(a3, b3, 32, 8, sm_s, er, el);
            check("sw_c8w32_lat", 32'(lat3), 32'(el));
            check("sw_c8w32_res", 32'(r3), 32'(er));
            check("sw_c8w32_onehot", 32'($countones(r3)), 32'd1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
